// File: rtl/cvt_sched_pkg.sv
// rtl/cvt_sched_pkg.sv - shared types and constants for the converter source scheduler
// Contents:
//   state_t            scheduler FSM states
//   WORD_BYTES         bytes per converter input word
//   WB_SHIFT           log2(WORD_BYTES)
//   GROUP_WORDS        input words per 48-bit output group
//   DEFAULT_HIGH_WATER default occupancy stall threshold
//   bytes_to_words()   ceil(bytes / WORD_BYTES) in 31 bits
package cvt_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    STREAM,
    DRAIN
  } state_t;

  localparam int WORD_BYTES         = 4;
  localparam int WB_SHIFT           = $clog2(WORD_BYTES);
  localparam int GROUP_WORDS        = 3;
  localparam int DEFAULT_HIGH_WATER = 240;

  // Widened by one bit so a size near 2^32 does not wrap before the shift.
  function automatic logic [30:0] bytes_to_words(input logic [31:0] bytes);
    logic [32:0] padded;
    padded = {1'b0, bytes} + 33'(WORD_BYTES - 1);
    return 31'(padded >> WB_SHIFT);
  endfunction

endpackage

// File: rtl/cvt_rr_arbiter.sv
// rtl/cvt_rr_arbiter.sv - combinational round-robin pick over a pending vector
// Ports:
//   pending     in  NUM_SRC  request bits
//   rr_ptr      in  IDX_W    index with highest priority this round
//   grant_idx   out IDX_W    first pending index at or after rr_ptr, wrapping
//   grant_valid out 1        any pending bit set
module cvt_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int               pos;
  logic [IDX_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest pending index
  // after rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = 0;
    idx         = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      idx = IDX_W'(pos);
      if (pending[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/cvt_src_scheduler.sv
// rtl/cvt_src_scheduler.sv - round-robin scheduler sharing one 32->48 converter among sources
// Optional feature macro: CVT_SCHED_STATS_EN (grant/stall statistics counters)
// Ports:
//   clk_wr          in  clock, rising edge
//   rst             in  asynchronous active-high reset
//   src_size_valid  in  per-source new transfer size pulse
//   src_size        in  per-source byte count, source i at [32i+31:32i]
//   src_empty       in  per-source queue empty
//   dst_occupancy   in  converter output-queue fill level
//   data_request    out one-hot per-word pop to the granted source
//   src_sel         out granted source index (data mux steer)
//   cvt_size_valid  out size pulse to converter
//   cvt_size        out byte count of granted transfer
//   cvt_flush       out pad/emit partial group pulse
//   busy            out a grant is active
//   xfer_done       out end-of-grant pulse
//   stat_grants     out per-source completed grants (16b each, saturating)
//   stat_stalls     out occupancy-stall cycles (wrapping)
module cvt_src_scheduler
  import cvt_sched_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int OCC_W      = 10,
  parameter int HIGH_WATER = DEFAULT_HIGH_WATER
) (
  input  logic                         clk_wr,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_size_valid,
  input  logic [NUM_SRC*32-1:0]        src_size,
  input  logic [NUM_SRC-1:0]           src_empty,
  input  logic [OCC_W-1:0]             dst_occupancy,
  output logic [NUM_SRC-1:0]           data_request,
  output logic [$clog2(NUM_SRC)-1:0]   src_sel,
  output logic                         cvt_size_valid,
  output logic [31:0]                  cvt_size,
  output logic                         cvt_flush,
  output logic                         busy,
  output logic                         xfer_done,
  output logic [NUM_SRC*16-1:0]        stat_grants,
  output logic [31:0]                  stat_stalls
);

  localparam int               IDX_W  = $clog2(NUM_SRC);
  localparam logic [OCC_W-1:0] HW_OCC = OCC_W'(HIGH_WATER);

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] pending;
  logic [31:0]        size_q [NUM_SRC];
  logic [IDX_W-1:0]   sel, rr_ptr, arb_idx;
  logic               arb_valid;
  logic [31:0]        gnt_size;
  logic [30:0]        words_left, words_after;
  logic [1:0]         grp_cnt;
  logic               req_q, occ_ok, pop_ok;

  cvt_rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_arb (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign occ_ok      = dst_occupancy < HW_OCC;
  assign pop_ok      = occ_ok && !src_empty[sel];
  // Words still owed once this cycle's pop (if any) is accounted for.
  assign words_after = words_left - {30'd0, req_q};

  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cvt_size_valid = 1'b0;
    xfer_done      = 1'b0;
    cvt_flush      = 1'b0;
    case (state)
      IDLE:   if (|pending) state_nxt = ARB;
      ARB:    state_nxt = arb_valid ? LOAD : IDLE;
      LOAD: begin
        cvt_size_valid = 1'b1;
        if (words_left == '0) begin
          xfer_done = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = STREAM;
        end
      end
      STREAM: if (req_q && words_left == 31'd1) state_nxt = DRAIN;
      DRAIN: begin
        cvt_flush = grp_cnt != 2'd0;
        xfer_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      for (int i = 0; i < NUM_SRC; i++) size_q[i] <= '0;
      sel        <= '0;
      rr_ptr     <= '0;
      gnt_size   <= '0;
      words_left <= '0;
      grp_cnt    <= '0;
      req_q      <= 1'b0;
    end else begin
      // A new size pulse wins over the grant-time clear, so a re-request
      // arriving while granted is kept for a later round.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_size_valid[i]) begin
          pending[i] <= 1'b1;
          size_q[i]  <= src_size[32*i +: 32];
        end else if (state == ARB && arb_valid && arb_idx == IDX_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
      if (state == ARB && arb_valid) begin
        sel        <= arb_idx;
        gnt_size   <= size_q[arb_idx];
        words_left <= bytes_to_words(size_q[arb_idx]);
        grp_cnt    <= '0;
      end
      if (state == STREAM && req_q) begin
        words_left <= words_left - 31'd1;
        grp_cnt    <= (grp_cnt == 2'(GROUP_WORDS - 1)) ? 2'd0 : grp_cnt + 2'd1;
      end
      if (xfer_done) rr_ptr <= (sel == IDX_W'(NUM_SRC - 1)) ? '0 : sel + IDX_W'(1);
      // Pop decision for next cycle is registered from this cycle's inputs.
      req_q <= (state_nxt == STREAM) && (words_after != '0) && pop_ok;
    end
  end

  always_comb begin
    data_request = '0;
    if (req_q) data_request[sel] = 1'b1;
  end

  assign src_sel  = sel;
  assign cvt_size = gnt_size;
  assign busy     = state != IDLE;

`ifdef CVT_SCHED_STATS_EN
  logic [15:0] grants_q [NUM_SRC];
  logic [31:0] stalls_q;

  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) grants_q[i] <= '0;
      stalls_q <= '0;
    end else begin
      if (xfer_done && grants_q[sel] != 16'hFFFF) grants_q[sel] <= grants_q[sel] + 16'd1;
      if (state == STREAM && !occ_ok && !src_empty[sel]) stalls_q <= stalls_q + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_stat
    assign stat_grants[16*g +: 16] = grants_q[g];
  end
  assign stat_stalls = stalls_q;
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif

endmodule
